// File: rtl/rv32i_types.sv
// Shared RV32I types for the fetch/execute path.
// Holds the branch-target-buffer op encoding and entry layout.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        null_op = 2'b00,
        jal_op  = 2'b01,
        jalr_op = 2'b10,
        br_op   = 2'b11
    } pc_branch_target_ops;

    // Tag is sized for the smallest legal index width; unused high bits stay 0.
    typedef struct packed {
        logic      valid;
        logic [29:0] tag;
        rv32i_word target;
        logic [1:0] ctr;
        logic      uncond;
    } btb_entry_t;

endpackage

// File: rtl/btb_ctr_update.sv
// Two-bit saturating direction counter next-state logic.
// Taken counts up to 2'b11, not-taken counts down to 2'b00.
module btb_ctr_update (
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/pc_branch_target_buffer.sv
// Direct-mapped branch target buffer with a registered lookup port
// and write-first forwarding from the execute-stage update port.
module pc_branch_target_buffer
    import rv32i_types::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                lookup_req,
    input  rv32i_word           lookup_pc,
    output logic                lookup_resp,
    output logic                lookup_hit,
    output logic                lookup_taken,
    output rv32i_word           lookup_target,
    input  logic                update_valid,
    input  pc_branch_target_ops update_op,
    input  rv32i_word           update_pc,
    input  rv32i_word           update_target,
    input  logic                update_taken
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [29:0]        tag_q    [ENTRIES];
    rv32i_word          target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic               uncond_q [ENTRIES];

    logic [INDEX_BITS-1:0] uidx;
    logic [INDEX_BITS-1:0] lidx;
    logic [29:0]           utag;
    logic [29:0]           ltag;
    logic                  unused_bits;

    assign uidx = update_pc[INDEX_BITS+1:2];
    assign lidx = lookup_pc[INDEX_BITS+1:2];
    assign utag = 30'(update_pc[31:INDEX_BITS+2]);
    assign ltag = 30'(lookup_pc[31:INDEX_BITS+2]);
    assign unused_bits = ^update_pc[1:0];

    btb_entry_t ucur;
    btb_entry_t unxt;
    btb_entry_t lcur;
    btb_entry_t lent;
    logic       uhit;
    logic       we;
    logic [1:0] ctr_next;
    logic       lhit;
    logic       ltaken;
    rv32i_word  ltgt;

    always_comb begin
        ucur = '{valid_q[uidx], tag_q[uidx], target_q[uidx],
                 ctr_q[uidx], uncond_q[uidx]};
        lcur = '{valid_q[lidx], tag_q[lidx], target_q[lidx],
                 ctr_q[lidx], uncond_q[lidx]};
    end

    assign uhit = ucur.valid && (ucur.tag == utag);

    btb_ctr_update u_ctr (
        .ctr      (ucur.ctr),
        .taken    (update_taken),
        .ctr_next (ctr_next)
    );

    always_comb begin
        we   = 1'b0;
        unxt = ucur;
        if (update_valid && !flush) begin
            unique case (update_op)
                jal_op, jalr_op: begin
                    we   = 1'b1;
                    unxt = '{1'b1, utag, update_target & ~32'h1,
                             2'b11, 1'b1};
                end
                br_op: begin
                    if (uhit) begin
                        // A conditional hit demotes an unconditional entry.
                        we          = 1'b1;
                        unxt.ctr    = ctr_next;
                        unxt.uncond = 1'b0;
                        if (update_taken)
                            unxt.target = update_target & ~32'h1;
                    end else if (update_taken) begin
                        we   = 1'b1;
                        unxt = '{1'b1, utag, update_target & ~32'h1,
                                 2'b10, 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-first: a same-edge update to the looked-up index is forwarded.
    always_comb begin
        lent   = (we && (uidx == lidx)) ? unxt : lcur;
        lhit   = !flush && lent.valid && (lent.tag == ltag);
        ltaken = lhit && (lent.uncond || lent.ctr[1]);
        ltgt   = ltaken ? lent.target : lookup_pc + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[uidx] <= unxt.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[uidx]    <= unxt.tag;
            target_q[uidx] <= unxt.target;
            ctr_q[uidx]    <= unxt.ctr;
            uncond_q[uidx] <= unxt.uncond;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_resp   <= 1'b0;
            lookup_hit    <= 1'b0;
            lookup_taken  <= 1'b0;
            lookup_target <= '0;
        end else begin
            lookup_resp <= lookup_req;
            if (lookup_req) begin
                lookup_hit    <= lhit;
                lookup_taken  <= ltaken;
                lookup_target <= ltgt;
            end
        end
    end

    if (TAG_BITS < 1) begin : g_bad_index
        $error("INDEX_BITS too large");
    end

endmodule

// File: tb/tb_pc_branch_target_buffer.sv
// Self-checking bench: behavioural BTB model compared every cycle,
// plus directed lookups pinned to hand-computed literals.
module tb_pc_branch_target_buffer;
    import rv32i_types::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic                lookup_req = 1'b0;
    logic [31:0]         lookup_pc = '0;
    logic                lookup_resp;
    logic                lookup_hit;
    logic                lookup_taken;
    logic [31:0]         lookup_target;
    logic                update_valid = 1'b0;
    pc_branch_target_ops update_op = null_op;
    logic [31:0]         update_pc = '0;
    logic [31:0]         update_target = '0;
    logic                update_taken = 1'b0;

    int tests = 0;
    int fails = 0;

    pc_branch_target_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .lookup_req    (lookup_req),
        .lookup_pc     (lookup_pc),
        .lookup_resp   (lookup_resp),
        .lookup_hit    (lookup_hit),
        .lookup_taken  (lookup_taken),
        .lookup_target (lookup_target),
        .update_valid  (update_valid),
        .update_op     (update_op),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken)
    );

    always #5 clk = ~clk;

    // Model: 16 entries, index pc[5:2], tag pc[31:6].
    bit          mv   [16];
    logic [31:0] mtag [16];
    logic [31:0] mtgt [16];
    int          mctr [16];
    bit          mu   [16];
    bit          er, eh, et;
    logic [31:0] etg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (mv[i]) mv[i] = 1'b0;
            er = 0; eh = 0; et = 0; etg = '0;
        end else begin
            int ix;
            bit h;
            er = lookup_req;
            if (flush) begin
                foreach (mv[i]) mv[i] = 1'b0;
            end else if (update_valid) begin
                ix = int'(update_pc[5:2]);
                h  = mv[ix] && (mtag[ix] == (update_pc >> 6));
                if (update_op == jal_op || update_op == jalr_op) begin
                    mv[ix] = 1; mtag[ix] = update_pc >> 6;
                    mtgt[ix] = update_target & ~32'h1;
                    mctr[ix] = 3; mu[ix] = 1;
                end else if (update_op == br_op) begin
                    if (h) begin
                        mu[ix] = 0;
                        if (update_taken) begin
                            mctr[ix] = (mctr[ix] == 3) ? 3 : mctr[ix] + 1;
                            mtgt[ix] = update_target & ~32'h1;
                        end else begin
                            mctr[ix] = (mctr[ix] == 0) ? 0 : mctr[ix] - 1;
                        end
                    end else if (update_taken) begin
                        mv[ix] = 1; mtag[ix] = update_pc >> 6;
                        mtgt[ix] = update_target & ~32'h1;
                        mctr[ix] = 2; mu[ix] = 0;
                    end
                end
            end
            if (lookup_req) begin
                ix  = int'(lookup_pc[5:2]);
                eh  = mv[ix] && (mtag[ix] == (lookup_pc >> 6));
                et  = eh && (mu[ix] || mctr[ix] >= 2);
                etg = et ? mtgt[ix] : lookup_pc + 32'd4;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_resp", 32'(lookup_resp), 32'(er));
            chk("cmp_hit", 32'(lookup_hit), 32'(eh));
            chk("cmp_taken", 32'(lookup_taken), 32'(et));
            chk("cmp_target", lookup_target, etg);
        end
    end

    task automatic step(input bit lr, input logic [31:0] lp, input bit uv,
                        input pc_branch_target_ops op, input logic [31:0] up,
                        input logic [31:0] ut, input bit tk, input bit fl);
        lookup_req = lr; lookup_pc = lp;
        update_valid = uv; update_op = op; update_pc = up;
        update_target = ut; update_taken = tk; flush = fl;
        @(posedge clk);
        #1;
        lookup_req = 0; update_valid = 0; update_op = null_op;
        update_taken = 0; flush = 0;
    endtask

    task automatic look(input logic [31:0] pc);
        step(1, pc, 0, null_op, 0, 0, 0, 0);
    endtask

    task automatic upd(input pc_branch_target_ops op, input logic [31:0] pc,
                       input logic [31:0] t, input bit tk);
        step(0, 0, 1, op, pc, t, tk, 0);
    endtask

    task automatic expect_lk(input string n, input bit h, input bit t,
                             input logic [31:0] tg);
        chk({n, "_resp"}, 32'(lookup_resp), 32'd1);
        chk({n, "_hit"}, 32'(lookup_hit), 32'(h));
        chk({n, "_taken"}, 32'(lookup_taken), 32'(t));
        chk({n, "_target"}, lookup_target, tg);
    endtask

    initial begin
        #12 rst = 0;
        @(posedge clk); #1;
        chk("reset_resp", 32'(lookup_resp), 32'd0);
        chk("reset_target", lookup_target, 32'd0);

        look(32'h100);
        expect_lk("cold_miss", 0, 0, 32'h104);
        @(posedge clk); #1;
        chk("idle_resp", 32'(lookup_resp), 32'd0);

        upd(jal_op, 32'h100, 32'h200, 0);
        look(32'h100);
        expect_lk("jal_hit", 1, 1, 32'h200);
        look(32'h140);
        expect_lk("alias_miss", 0, 0, 32'h144);

        upd(br_op, 32'h80, 32'h40, 1);
        look(32'h80);
        expect_lk("br_alloc", 1, 1, 32'h40);
        upd(br_op, 32'h80, 32'h40, 0);
        upd(br_op, 32'h80, 32'h40, 0);
        look(32'h80);
        expect_lk("ctr_00", 1, 0, 32'h84);
        repeat (4) upd(br_op, 32'h80, 32'h40, 1);
        upd(br_op, 32'h80, 32'h40, 0);
        look(32'h80);
        expect_lk("ctr_sat_10", 1, 1, 32'h40);
        upd(br_op, 32'h80, 32'h40, 0);
        look(32'h80);
        expect_lk("ctr_sat_01", 1, 0, 32'h84);

        upd(br_op, 32'h300, 32'h900, 0);
        look(32'h300);
        expect_lk("nt_no_alloc", 0, 0, 32'h304);
        upd(jalr_op, 32'h400, 32'h1235, 0);
        look(32'h400);
        expect_lk("jalr_bit0", 1, 1, 32'h1234);

        step(1, 32'h10, 1, jal_op, 32'h10, 32'h500, 0, 0);
        expect_lk("fwd_same_edge", 1, 1, 32'h500);
        step(1, 32'h20, 1, jal_op, 32'h20, 32'h600, 0, 1);
        expect_lk("flush_lookup", 0, 0, 32'h24);
        look(32'h20);
        expect_lk("flush_no_write", 0, 0, 32'h24);
        look(32'h10);
        expect_lk("flush_cleared", 0, 0, 32'h14);

        upd(jal_op, 32'h30, 32'h700, 0);
        upd(br_op, 32'h30, 32'h0, 0);
        look(32'h30);
        expect_lk("demote_10", 1, 1, 32'h700);
        upd(br_op, 32'h30, 32'h0, 0);
        look(32'h30);
        expect_lk("demote_01", 1, 0, 32'h34);

        upd(jal_op, 32'h100, 32'h200, 0);
        look(32'hFFFF_FFFC);
        expect_lk("wrap", 0, 0, 32'h0);
        look(32'h100);
        look(32'h100);
        expect_lk("back_to_back", 1, 1, 32'h200);

        look(32'h100);
        #1 rst = 1;
        #1;
        chk("async_rst_resp", 32'(lookup_resp), 32'd0);
        chk("async_rst_hit", 32'(lookup_hit), 32'd0);
        chk("async_rst_target", lookup_target, 32'd0);
        #1 rst = 0;
        @(posedge clk); #1;
        look(32'h100);
        expect_lk("post_rst_miss", 0, 0, 32'h104);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
